flash_adc_sequencer: RTL
========================

Name: flash_adc_sequencer

Overview:
Parametrised digital back-end for the resistor/op-amp comparator ladder (flash ADC).
- Synchronises the thermometer-coded comparator outputs and encodes them to binary.
- Sequences conversions: single-shot on a debounced button press, or continuous.
- Oversamples and accumulates 2^OSR_LOG2 samples per result, flags non-monotonic (bubble) codes, and gates ladder bias through ladder_en.
- Sits between the analog ladder outputs and the dedicated digital output pins.

Parameters:
BITS, 2, binary code width; ladder provides LEVELS = 2^BITS-1 comparator outputs (derived localparam)
OSR_LOG2, 2, log2 of samples accumulated per result (0 = no oversampling)
SETTLE_CYCLES, 4, cycles ladder_en is high before first sample; must be >= 3 (elaboration check)
DEBOUNCE_CYCLES, 16, cycles the synchronised btn must be stable before the debounced level changes; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn  in  1  raw push-button, asynchronous
mode  in  1  0 = single-shot per press, 1 = continuous; sampled only in IDLE and DONE
therm_in  in  LEVELS  comparator outputs, asynchronous, bit i set when input > reference i
ladder_en  out  1  enables ladder/op-amp bias
busy  out  1  high in any state other than IDLE
result  out  BITS+OSR_LOG2  sum of encoded samples of the last conversion
result_valid  out  1  one-cycle pulse when result updates
result_bubble  out  1  high if any sample of the last conversion was non-monotonic
control  out  3  debug {ladder_en, state[1:0]}

Behaviour:
- Reset (async assert, sync release): state IDLE; ladder_en, busy, result, result_valid, result_bubble, control all 0; synchronisers, debounce counter, debounced level and accumulator all 0.
- therm_in: 2-flop synchroniser, then a registered encode stage.
  - code = popcount(therm), range 0..LEVELS, which tolerates bubbles.
  - bubble = exists i>0 with t[i]=1 and t[i-1]=0.
  - Total therm-to-code latency is 3 cycles; the SETTLE_CYCLES >= 3 rule covers it.
- btn: 2-flop synchroniser, then debounce.
  - Counter resets whenever the synchronised value equals the debounced level.
  - Debounced level flips when the counter reaches DEBOUNCE_CYCLES-1.
  - start = one-cycle pulse on the debounced rising edge.
  - A button held through reset yields one start after debounce.
- FSM encoding: IDLE=0, SETTLE=1, SAMPLE=2, DONE=3.
  - IDLE -> SETTLE when (mode=0 and start) or mode=1. Entering SETTLE: ladder_en=1, accumulator and bubble accumulator cleared.
  - SETTLE stays exactly SETTLE_CYCLES cycles, then -> SAMPLE.
  - SAMPLE stays exactly 2^OSR_LOG2 cycles. Each cycle: acc += code; bub_acc |= bubble.
  - DONE lasts 1 cycle. On entry, result <= acc final and result_bubble <= bub_acc final (including the last sample). result_valid=1 only in this cycle.
  - DONE -> SAMPLE if mode=1; acc and bub_acc are cleared and ladder_en stays 1, giving period 2^OSR_LOG2+1.
  - DONE -> IDLE if mode=0; ladder_en=0 from the IDLE cycle onward.
- Timing: start pulse at cycle T gives SETTLE T+1..T+SETTLE_CYCLES, then SAMPLE, then DONE at T+SETTLE_CYCLES+2^OSR_LOG2+1.
- start while busy is ignored and not queued.
- mode changes mid-conversion take effect only at DONE or IDLE.
- Accumulator width is BITS+OSR_LOG2 and cannot overflow, since the maximum is LEVELS*2^OSR_LOG2 < 2^(BITS+OSR_LOG2).
- result and result_bubble hold between conversions.
- rst_n asserted in any state clears all state immediately; no partial result is emitted.

Decomposition:
- Package flash_adc_pkg holds:
  - state enum (IDLE/SETTLE/SAMPLE/DONE, 2 bits);
  - functions therm_popcount and therm_is_bubble, parametrised by LEVELS;
  - localparam helpers for LEVELS and the result width.
- Sub-module adc_btn_debounce (synchroniser + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES, clk/rst_n).
- Therm synchroniser, encoder and FSM stay in the top module.

Test Plan:
1. Defaults, therm_in=3'b011 held, one clean press -> exactly one result_valid pulse at start+9 cycles, result=8, result_bubble=0, ladder_en high T+1..T+8 and low from T+10.
2. btn toggling every 5 cycles for 40 cycles, then steady high for 30 -> exactly one start and one conversion; no start during bounce.
3. therm_in=3'b101 held, single press -> result=8 (code 2 x4), result_bubble=1; next press with 3'b001 -> result=4, result_bubble=0.
4. mode=1, therm_in=3'b111 -> first result_valid 9 cycles after leaving IDLE, then every 5 cycles, result=12 each, ladder_en continuously 1. Clear mode mid-SAMPLE -> current result completes, then IDLE, ladder_en=0.
5. Press again while in SAMPLE -> ignored; exactly one result_valid.
6. rst_n low for 1 cycle mid-SAMPLE -> all outputs 0 immediately, FSM IDLE, no result_valid. Sweep with BITS=3, OSR_LOG2=0, therm_in=7'b0011111 -> result=5.

Source files
------------

// File: rtl/flash_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flash_adc_pkg
// Description : Shared types and thermometer-code helpers for the flash ADC.
// Revision    : 1.0
// ============================================================================
package flash_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned MAX_BITS   = 8;
    localparam int unsigned MAX_LEVELS = (1 << MAX_BITS) - 1;

    function automatic int unsigned levels_of(input int unsigned bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int unsigned result_width(input int unsigned bits,
                                                 input int unsigned osr_log2);
        return bits + osr_log2;
    endfunction

    // Counting ones rather than finding the top set bit keeps the code sane
    // when a comparator near the threshold glitches.
    function automatic int unsigned therm_popcount(input logic [MAX_LEVELS-1:0] therm,
                                                   input int unsigned           levels);
        int unsigned count;
        count = 0;
        for (int i = 0; i < MAX_LEVELS; i++) begin
            if ((i < int'(levels)) && therm[i]) begin
                count = count + 1;
            end
        end
        return count;
    endfunction

    function automatic logic therm_is_bubble(input logic [MAX_LEVELS-1:0] therm,
                                             input int unsigned           levels);
        logic bubble;
        bubble = 1'b0;
        for (int i = 1; i < MAX_LEVELS; i++) begin
            if ((i < int'(levels)) && therm[i] && !therm[i-1]) begin
                bubble = 1'b1;
            end
        end
        return bubble;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : adc_btn_debounce
// Description : Button synchroniser, debounce filter and rising-edge start pulse.
// Revision    : 1.0
// ============================================================================
module adc_btn_debounce
    import flash_adc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic start_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("adc_btn_debounce: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          start_q;
    logic          start_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        start_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    assign start_o = start_q;

endmodule
`default_nettype wire

// File: rtl/flash_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flash_adc_sequencer
// Description : Flash ADC back-end: therm sync/encode, conversion FSM, oversampling.
// Revision    : 1.0
// ============================================================================
module flash_adc_sequencer
    import flash_adc_pkg::*;
#(
    parameter int unsigned BITS            = 2,
    parameter int unsigned OSR_LOG2        = 2,
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn,
    input  logic                       mode,
    input  logic [(2**BITS)-2:0]       therm_in,
    output logic                       ladder_en,
    output logic                       busy,
    output logic [BITS+OSR_LOG2-1:0]   result,
    output logic                       result_valid,
    output logic                       result_bubble,
    output logic [2:0]                 control
);

    localparam int unsigned LEVELS      = levels_of(BITS);
    localparam int unsigned RW          = result_width(BITS, OSR_LOG2);
    localparam int unsigned OSR_SAMPLES = 1 << OSR_LOG2;
    localparam int unsigned CNT_MAX     = (SETTLE_CYCLES > OSR_SAMPLES) ? SETTLE_CYCLES
                                                                        : OSR_SAMPLES;
    localparam int unsigned CW          = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(OSR_SAMPLES - 1);

    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("flash_adc_sequencer: SETTLE_CYCLES must be >= 3");
        end
        if ((BITS < 1) || (BITS > MAX_BITS)) begin : g_bad_bits
            $error("flash_adc_sequencer: BITS out of supported range");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Comparator synchroniser and encode stage (3 cycles therm -> code)
    // ------------------------------------------------------------------------
    logic [LEVELS-1:0] therm_meta_q;
    logic [LEVELS-1:0] therm_sync_q;
    logic [BITS-1:0]   code_q;
    logic [BITS-1:0]   code_d;
    logic              bubble_q;
    logic              bubble_d;

    always_comb begin
        code_d   = BITS'(therm_popcount(MAX_LEVELS'(therm_sync_q), LEVELS));
        bubble_d = therm_is_bubble(MAX_LEVELS'(therm_sync_q), LEVELS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            therm_meta_q <= '0;
            therm_sync_q <= '0;
            code_q       <= '0;
            bubble_q     <= 1'b0;
        end else begin
            therm_meta_q <= therm_in;
            therm_sync_q <= therm_meta_q;
            code_q       <= code_d;
            bubble_q     <= bubble_d;
        end
    end

    logic start;

    adc_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn),
        .start_o (start)
    );

    // ------------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------------
    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [RW-1:0]   acc_q;
    logic [RW-1:0]   acc_d;
    logic            bub_acc_q;
    logic            bub_acc_d;
    logic [RW-1:0]   result_q;
    logic [RW-1:0]   result_d;
    logic            result_bubble_q;
    logic            result_bubble_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + CW'(1);
        acc_d           = acc_q;
        bub_acc_d       = bub_acc_q;
        result_d        = result_q;
        result_bubble_d = result_bubble_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mode || start) begin
                    state_d   = ST_SETTLE;
                    acc_d     = '0;
                    bub_acc_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end
            end
            ST_SAMPLE: begin
                acc_d     = acc_q + RW'(code_q);
                bub_acc_d = bub_acc_q | bubble_q;
                // The last sample is folded into the published result directly.
                if (cnt_q == SAMPLE_LAST) begin
                    state_d         = ST_DONE;
                    cnt_d           = '0;
                    result_d        = acc_d;
                    result_bubble_d = bub_acc_d;
                end
            end
            ST_DONE: begin
                cnt_d     = '0;
                acc_d     = '0;
                bub_acc_d = 1'b0;
                state_d   = mode ? ST_SAMPLE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            acc_q           <= '0;
            bub_acc_q       <= 1'b0;
            result_q        <= '0;
            result_bubble_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            bub_acc_q       <= bub_acc_d;
            result_q        <= result_d;
            result_bubble_q <= result_bubble_d;
        end
    end

    always_comb begin
        ladder_en     = (state_q != ST_IDLE);
        busy          = (state_q != ST_IDLE);
        result_valid  = (state_q == ST_DONE);
        result        = result_q;
        result_bubble = result_bubble_q;
        control       = {(state_q != ST_IDLE), state_q};
    end

endmodule
`default_nettype wire
